mux_scan_ctrl: RTL and testbench
================================

# mux_scan_ctrl

Scan sequencer for the 8-to-1 bit multiplexer. It drives `MUX_sel` through channels 0..7 and holds each channel for a programmable dwell time. At the end of each dwell it samples the mux's `MUX_out` return and assembles the eight samples into a byte. The byte is published atomically with a one-cycle `done` pulse, and the block supports single-shot and continuous scanning.

## Interface

Parameters:
- `DWELL`, default 2: cycles each channel is held before sampling; legal range 1..256.
- `CW`, default `$clog2(DWELL)` (min 1): width of the dwell counter; derived, never overridden.

Ports:
- `clk`  input  1  — the block's single clock.
- `rst`  input  1  — synchronous reset, active-high.
- `start`  input  1  — level-sampled request to begin a scan; honoured only in IDLE.
- `stop`  input  1  — abort the current scan and return to IDLE; overrides `start`.
- `cont`  input  1  — continuous mode; sampled at scan completion.
- `MUX_out`  input  1  — bit returned by the mux for the current `MUX_sel`.
- `MUX_sel`  output  3  — registered channel select to the mux.
- `busy`  output  1  — high while a scan is in progress.
- `done`  output  1  — one-cycle pulse when `scan_data` updates.
- `scan_data`  output  8  — last complete scan; bit n holds the sample from channel n.

## Operation

- **Reset:** `MUX_sel`=0, `busy`=0, `done`=0, `scan_data`=8'h00. The shadow register is cleared, the dwell counter is set to 0, and the state is IDLE.
- **States:** IDLE and SCAN.
- **IDLE:**
  - `MUX_sel` is held at 0 and `busy`=0.
  - On `start`=1 with `stop`=0: load the counter with DWELL-1, set `MUX_sel`=0, set `busy`=1, go to SCAN.
- **SCAN, counter ≠ 0:** decrement the counter; `MUX_sel` is unchanged.
- **SCAN, counter = 0:** write shadow[`MUX_sel`] ← `MUX_out`. Then:
  - If `MUX_sel` ≠ 7: increment `MUX_sel` and reload the counter with DWELL-1.
  - If `MUX_sel` = 7:
    - Load `scan_data` with the shadow, including the bit sampled this edge.
    - Pulse `done`.
    - Set `MUX_sel`=0.
    - If `cont`=1: reload the counter, stay in SCAN, keep `busy`=1.
    - Otherwise: go to IDLE and set `busy`=0.
- **stop in SCAN:** on any edge with `stop`=1, go to IDLE with `MUX_sel`=0 and `busy`=0.
  - `stop` takes priority over a same-edge sample or completion.
  - No `done` is generated and `scan_data` is not modified.
  - The shadow contents are don't-care.
- **start outside IDLE:** `start` while SCAN is ignored; it is neither queued nor does it restart the scan.
- **Atomic update:** `scan_data` changes only on the completion edge and never shows a partial scan.
- **Counter width:** with DWELL=1 the counter is always 0, so one channel is sampled per cycle.

## Timing

- **Start edge:** `start` accepted at edge E. From E onward, `busy`=1 and `MUX_sel`=0.
- **Sampling:** channel n is driven during edges E+n·DWELL .. E+(n+1)·DWELL and sampled at edge E+(n+1)·DWELL.
  - `MUX_sel` is therefore stable for exactly DWELL cycles before each sample.
  - The mux path is combinational, so it needs one cycle of settling.
- **Completion edge E+8·DWELL:**
  - `scan_data` is valid.
  - `done`=1 for exactly one cycle.
  - `busy`=0 in single-shot mode.
- **Latency:** start-to-done is 8·DWELL cycles.
- **Back-to-back single-shot:** a new `start` is accepted no earlier than edge E+8·DWELL+1.
- **Continuous mode:**
  - Scans repeat with period 8·DWELL and no idle gap.
  - `done` pulses every 8·DWELL cycles.
  - `cont` is examined only on completion edges. Dropping it mid-scan ends scanning after the current scan.
- **Reset mid-scan:** all outputs return to their reset values on the next edge; no `done` is generated.

## Test plan

- **Basic single-shot:** DWELL=2, `MUX_in`=8'hA5 static, `start` pulsed at edge 0.
  - `MUX_sel` steps 0,1,…,7, each held 2 cycles.
  - `done` is high only after edge 16; `scan_data`=8'hA5; `busy` is high for edges 0..15.
- **DWELL=1:** `MUX_in`=8'h3C.
  - `MUX_sel` increments every cycle.
  - `done` after edge 8; `scan_data`=8'h3C.
- **Continuous mode:** DWELL=2, `cont`=1.
  - `MUX_in` is 8'hFF for the first scan and switched to 8'h00 at the first `done`.
  - `done` pulses at edges 16 and 32 with `scan_data` 8'hFF then 8'h00; `busy` never drops.
  - Deasserting `cont` before edge 48 gives a final `done` at 48, after which `busy`=0.
- **Stop mid-scan:** previous `scan_data`=8'h12, `stop` asserted at edge 7.
  - State returns to IDLE with `MUX_sel`=0 and `busy`=0.
  - No `done`; `scan_data` stays 8'h12.
  - `start` and `stop` together in IDLE: no scan begins.
- **Reset mid-scan:** `rst` asserted at edge 9 of a DWELL=2 scan.
  - All outputs are 0 after the edge; no `done`.
  - A fresh scan afterwards completes normally.
- **start while busy:** `start` is re-pulsed at edges 3 and 10.
  - Ignored; completion stays at edge 16 and only one `done` is generated.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if
//   Groups the scan request/response and mux signals of mux_scan_ctrl.
//   master : scan requester plus mux model (drives start/stop/cont/MUX_out).
//   slave  : the scan sequencer (drives MUX_sel/busy/done/scan_data).
//   Signals:
//     start     - level request to begin a scan (honoured only when idle)
//     stop      - abort the current scan, overrides start
//     cont      - continuous mode, examined at scan completion
//     MUX_out   - bit returned by the mux for the current MUX_sel
//     MUX_sel   - channel select to the mux
//     busy      - scan in progress
//     done      - one-cycle pulse when scan_data updates
//     scan_data - last complete scan, bit n = channel n
interface mux_scan_ctrl_if;
    logic       start;
    logic       stop;
    logic       cont;
    logic       MUX_out;
    logic [2:0] MUX_sel;
    logic       busy;
    logic       done;
    logic [7:0] scan_data;

    modport master (
        output start, stop, cont, MUX_out,
        input  MUX_sel, busy, done, scan_data
    );

    modport slave (
        input  start, stop, cont, MUX_out,
        output MUX_sel, busy, done, scan_data
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scan sequencer for an 8-to-1 bit mux. Steps MUX_sel through channels
//   0..7, holding each for DWELL cycles, samples MUX_out at the end of each
//   dwell and publishes the assembled byte atomically with a done pulse.
//   Supports single-shot and continuous scanning.
//   Ports:
//     clk - clock
//     rst - synchronous reset, active-high
//     bus - mux_scan_ctrl_if.slave (start/stop/cont/MUX_out in,
//           MUX_sel/busy/done/scan_data out)
//   Parameters:
//     DWELL - cycles each channel is held before sampling (1..256)
//     CW    - dwell counter width, derived from DWELL
module mux_scan_ctrl #(
    parameter  int DWELL = 2,
    localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1
) (
    input  logic               clk,
    input  logic               rst,
    mux_scan_ctrl_if.slave     bus
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    state_t        state_q, state_d;
    logic [2:0]    sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [7:0]    data_q, data_d;
    logic          done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sel_q    <= 3'd0;
            cnt_q    <= '0;
            shadow_q <= 8'h00;
            data_q   <= 8'h00;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                sel_d = 3'd0;
                if (bus.start && !bus.stop) begin
                    cnt_d   = RELOAD;
                    state_d = SCAN;
                end
            end

            SCAN: begin
                if (bus.stop) begin
                    // Abort wins over any same-edge sample or completion.
                    sel_d   = 3'd0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shadow_d[sel_q] = bus.MUX_out;
                    if (sel_q != 3'd7) begin
                        sel_d = sel_q + 3'd1;
                        cnt_d = RELOAD;
                    end else begin
                        // Channel 7 is sampled on this edge, so it bypasses
                        // the shadow to keep the published byte complete.
                        data_d = {bus.MUX_out, shadow_q[6:0]};
                        done_d = 1'b1;
                        sel_d  = 3'd0;
                        if (bus.cont) begin
                            cnt_d = RELOAD;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.MUX_sel   = sel_q;
    assign bus.busy      = (state_q == SCAN);
    assign bus.done      = done_q;
    assign bus.scan_data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
//   Drives two sequencers (DWELL=2 and DWELL=1) from the same stimulus.
//   A reference model derives expected behaviour from elapsed cycles since
//   scan start; completed bytes go into per-lane queues that a monitor pops
//   whenever a DUT pulses done.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst;
    logic       start, stop, cont;
    logic [7:0] mux_in;

    mux_scan_ctrl_if bus2 ();
    mux_scan_ctrl_if bus1 ();

    assign bus2.start   = start;
    assign bus2.stop    = stop;
    assign bus2.cont    = cont;
    assign bus2.MUX_out = mux_in[bus2.MUX_sel];
    assign bus1.start   = start;
    assign bus1.stop    = stop;
    assign bus1.cont    = cont;
    assign bus1.MUX_out = mux_in[bus1.MUX_sel];

    mux_scan_ctrl #(.DWELL(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    mux_scan_ctrl #(.DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane 0 = DWELL 2, lane 1 = DWELL 1
    logic [2:0] sel_a  [2];
    logic       busy_a [2];
    logic       done_a [2];
    logic [7:0] data_a [2];

    assign sel_a[0]  = bus2.MUX_sel;
    assign busy_a[0] = bus2.busy;
    assign done_a[0] = bus2.done;
    assign data_a[0] = bus2.scan_data;
    assign sel_a[1]  = bus1.MUX_sel;
    assign busy_a[1] = bus1.busy;
    assign done_a[1] = bus1.done;
    assign data_a[1] = bus1.scan_data;

    // Reference model state
    bit         m_act  [2];
    int         m_el   [2];
    logic [7:0] m_acc  [2];
    logic [7:0] e_scan [2];
    logic [2:0] e_sel  [2];
    bit         e_busy [2];
    bit         e_done [2];

    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int checks   = 0;
    int failures = 0;
    bit end_req  = 1'b0;
    bit timeout_flag = 1'b0;

    always @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            int d;
            int ch;
            d = (l == 0) ? 2 : 1;
            e_done[l] = 1'b0;
            if (rst) begin
                m_act[l]  = 1'b0;
                m_el[l]   = 0;
                e_scan[l] = 8'h00;
            end else if (m_act[l]) begin
                if (stop) begin
                    m_act[l] = 1'b0;
                end else begin
                    m_el[l] = m_el[l] + 1;
                    if (m_el[l] % d == 0) begin
                        ch = m_el[l] / d - 1;
                        m_acc[l][ch] = mux_in[ch];
                    end
                    if (m_el[l] == 8 * d) begin
                        e_scan[l] = m_acc[l];
                        e_done[l] = 1'b1;
                        if (l == 0) exp_q0.push_back(m_acc[l]);
                        else        exp_q1.push_back(m_acc[l]);
                        if (cont) m_el[l] = 0;
                        else      m_act[l] = 1'b0;
                    end
                end
            end else if (start && !stop) begin
                m_act[l] = 1'b1;
                m_el[l]  = 0;
                m_acc[l] = 8'h00;
            end
            e_busy[l] = m_act[l];
            e_sel[l]  = m_act[l] ? 3'(m_el[l] / d) : 3'd0;
        end
    end

    task automatic chk(input string nm, input int l, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s lane%0d t=%0t actual=%h required=%h", nm, l, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (end_req) begin
            chk("queue0_drained", 0, 8'(exp_q0.size()), 8'd0);
            chk("queue1_drained", 1, 8'(exp_q1.size()), 8'd0);
            chk("wait_timeout", 0, 8'(timeout_flag), 8'd0);
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end else begin
            for (int l = 0; l < 2; l++) begin
                logic [7:0] exp_b;
                chk("busy", l, 8'(busy_a[l]), 8'(e_busy[l]));
                chk("mux_sel", l, 8'(sel_a[l]), 8'(e_sel[l]));
                chk("done", l, 8'(done_a[l]), 8'(e_done[l]));
                chk("scan_data_hold", l, data_a[l], e_scan[l]);
                if (done_a[l] === 1'b1) begin
                    if ((l == 0 && exp_q0.size() == 0) || (l == 1 && exp_q1.size() == 0)) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done lane%0d t=%0t actual=done required=no_done", l, $time);
                    end else begin
                        exp_b = (l == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        chk("scan_data_done", l, data_a[l], exp_b);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; mux_in = 8'h00;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic single-shot
        mux_in = 8'hA5;
        pulse_start();
        idle(20);

        // Second pattern (lane 1 exercises DWELL=1)
        mux_in = 8'h3C;
        pulse_start();
        idle(20);

        // Continuous: FF then 00 after first lane-0 done
        mux_in = 8'hFF;
        cont = 1'b1;
        pulse_start();
        begin
            int k;
            k = 0;
            while (done_a[0] !== 1'b1 && k < 40) begin
                @(negedge clk);
                k++;
            end
            if (done_a[0] !== 1'b1) timeout_flag = 1'b1;
        end
        mux_in = 8'h00;
        idle(20);
        cont = 1'b0;
        idle(30);

        // Stop mid-scan with scan_data = 12
        mux_in = 8'h12;
        pulse_start();
        idle(20);
        mux_in = 8'hED;
        pulse_start();
        idle(6);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        idle(3);
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        idle(5);

        // Reset mid-scan, then fresh scan
        pulse_start();
        idle(8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mux_in = 8'h5A;
        pulse_start();
        idle(20);

        // start re-pulsed while busy
        mux_in = 8'hC3;
        pulse_start();
        idle(2);
        pulse_start();
        idle(6);
        pulse_start();
        idle(20);

        // Randomized phase
        repeat (4000) begin
            start  = ($urandom_range(0, 7) == 0);
            stop   = ($urandom_range(0, 63) == 0);
            cont   = ($urandom_range(0, 2) != 0);
            rst    = ($urandom_range(0, 499) == 0);
            mux_in = 8'($urandom);
            @(negedge clk);
        end
        start = 1'b0; stop = 1'b0; cont = 1'b0; rst = 1'b0;
        idle(40);
        end_req = 1'b1;
    end

endmodule
